// File: rtl/meta_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// meta_ctrl_pkg
// Shared types and helpers for the metadata array controller.
//   ctrl_state_e : controller FSM state (IDLE serves requesters, SWEEP
//                  invalidates every set of the external array).
//   same_op_conflict() : true when two pending requests need the same array
//                  port (both reads or both writes) and must be arbitrated.
// No ports (package).
// -----------------------------------------------------------------------------
package meta_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } ctrl_state_e;

  // The array has one read port and one write port, so only two requests of
  // the same kind compete for a port.
  function automatic logic same_op_conflict(input logic req0, input logic req1,
                                            input logic we0,  input logic we1);
    return req0 && req1 && (we0 == we1);
  endfunction

endpackage

// File: rtl/meta_array_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter for one array port.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (prio returns to requester 0)
//   req[1:0] : requests already qualified by the controller
//   conflict : both requesters want the same port this cycle
//   gnt[1:0] : grants; without a conflict every request is granted directly
// The prio flop selects the winner of a conflict and flips only on a
// conflicting cycle, so uncontested traffic never disturbs the fairness order.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       conflict,
  output logic [1:0] gnt
);

  logic prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (conflict) begin
      prio <= ~prio;
    end
  end

  always_comb begin
    gnt = req;
    if (conflict) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/meta_array_ctrl.sv
// -----------------------------------------------------------------------------
// meta_array_ctrl
// Controller in front of an external 2**S_INDEX x WIDTH metadata array with one
// combinational read port and one write port (the array bypasses a same-cycle
// write to the read index). Two requesters share the ports; a flush request
// runs an invalidate sweep writing zero to every set.
//
// Ports
//   clk, rst                    : clock (rising edge), synchronous active-high reset
//   req0/1, we0/1, idx0/1,      : requester n operation: pending, 1=write/0=read,
//   wdata0/1                      target set, write data
//   ready0/1                    : requester n operation accepted this cycle
//   rvalid0/1, rdata0/1         : registered read data, one cycle after accept
//   flush_req                   : start an invalidate sweep (ignored during one)
//   flush_done                  : one-cycle pulse when the sweep completes
//   arr_read, arr_rindex        : array read strobe and index
//   arr_load, arr_windex,       : array write strobe, index and data
//   arr_datain
//   arr_dataout                 : array read data (combinational)
// -----------------------------------------------------------------------------
module meta_array_ctrl
  import meta_ctrl_pkg::*;
#(
  parameter int S_INDEX = 3,
  parameter int WIDTH   = 1
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0,
  input  logic               we0,
  input  logic [S_INDEX-1:0] idx0,
  input  logic [WIDTH-1:0]   wdata0,
  output logic               ready0,
  output logic               rvalid0,
  output logic [WIDTH-1:0]   rdata0,

  input  logic               req1,
  input  logic               we1,
  input  logic [S_INDEX-1:0] idx1,
  input  logic [WIDTH-1:0]   wdata1,
  output logic               ready1,
  output logic               rvalid1,
  output logic [WIDTH-1:0]   rdata1,

  input  logic               flush_req,
  output logic               flush_done,

  output logic               arr_read,
  output logic               arr_load,
  output logic [S_INDEX-1:0] arr_rindex,
  output logic [S_INDEX-1:0] arr_windex,
  output logic [WIDTH-1:0]   arr_datain,
  input  logic [WIDTH-1:0]   arr_dataout
);

  localparam logic [S_INDEX-1:0] LAST_IDX = '1;

  ctrl_state_e        state;
  ctrl_state_e        state_nxt;
  logic [S_INDEX-1:0] sweep_cnt;

  logic       grant_en;
  logic [1:0] arb_req;
  logic       arb_conflict;
  logic [1:0] gnt;
  logic       rd0, rd1, wr0, wr1;
  logic       sweep_last;

  // Grants are only possible in IDLE; a flush in the same cycle takes the
  // cycle, and nothing is accepted while reset is held.
  assign grant_en     = (state == IDLE) && !flush_req && !rst;
  assign arb_req      = {req1, req0} & {2{grant_en}};
  assign arb_conflict = grant_en && same_op_conflict(req0, req1, we0, we1);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .conflict (arb_conflict),
    .gnt      (gnt)
  );

  assign ready0 = gnt[0];
  assign ready1 = gnt[1];

  // After arbitration at most one read and at most one write are granted.
  assign rd0 = gnt[0] && !we0;
  assign wr0 = gnt[0] &&  we0;
  assign rd1 = gnt[1] && !we1;
  assign wr1 = gnt[1] &&  we1;

  assign sweep_last = (state == SWEEP) && (sweep_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= sweep_last;
      // Counting past LAST_IDX wraps to zero, leaving the counter ready for
      // the next sweep.
      if (state == SWEEP) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end else begin
        sweep_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    arr_read   = 1'b0;
    arr_load   = 1'b0;
    arr_rindex = '0;
    arr_windex = '0;
    arr_datain = '0;

    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = SWEEP;
        end
        arr_read   = rd0 || rd1;
        arr_rindex = rd1 ? idx1 : idx0;
        arr_load   = wr0 || wr1;
        if (wr1) begin
          arr_windex = idx1;
          arr_datain = wdata1;
        end else begin
          arr_windex = idx0;
          arr_datain = wdata0;
        end
      end

      SWEEP: begin
        arr_load   = 1'b1;
        arr_windex = sweep_cnt;
        arr_datain = '0;
        if (sweep_cnt == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The sweep write strobe would otherwise still fire while reset is held.
    if (rst) begin
      arr_load = 1'b0;
      arr_read = 1'b0;
    end
  end

  // Read returns are registered independently of the FSM so a read accepted
  // just before a sweep still delivers its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) begin
        rdata0 <= arr_dataout;
      end
      if (rd1) begin
        rdata1 <= arr_dataout;
      end
    end
  end

endmodule

// File: tb/tb_meta_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_meta_array_ctrl
// Directed bench for meta_array_ctrl with a behavioural external array.
// Expected read data is pushed to per-requester queues when a read is expected
// to be accepted and popped when rvalid is due one cycle later.
// -----------------------------------------------------------------------------
module tb_meta_array_ctrl;

  localparam int S_INDEX = 3;
  localparam int WIDTH   = 4;
  localparam int SETS    = 1 << S_INDEX;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0, we0, req1, we1;
  logic [S_INDEX-1:0] idx0, idx1;
  logic [WIDTH-1:0]   wdata0, wdata1;
  logic               ready0, ready1, rvalid0, rvalid1;
  logic [WIDTH-1:0]   rdata0, rdata1;
  logic               flush_req, flush_done;
  logic               arr_read, arr_load;
  logic [S_INDEX-1:0] arr_rindex, arr_windex;
  logic [WIDTH-1:0]   arr_datain, arr_dataout;
  logic               preload;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] arr_mem [SETS];
  logic [WIDTH-1:0] exp_mem [SETS];
  logic [WIDTH-1:0] sb0 [$];
  logic [WIDTH-1:0] sb1 [$];

  always #5 clk = ~clk;

  meta_array_ctrl #(.S_INDEX(S_INDEX), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .we0         (we0),
    .idx0        (idx0),
    .wdata0      (wdata0),
    .ready0      (ready0),
    .rvalid0     (rvalid0),
    .rdata0      (rdata0),
    .req1        (req1),
    .we1         (we1),
    .idx1        (idx1),
    .wdata1      (wdata1),
    .ready1      (ready1),
    .rvalid1     (rvalid1),
    .rdata1      (rdata1),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .arr_read    (arr_read),
    .arr_load    (arr_load),
    .arr_rindex  (arr_rindex),
    .arr_windex  (arr_windex),
    .arr_datain  (arr_datain),
    .arr_dataout (arr_dataout)
  );

  // External array: combinational read with same-cycle write bypass.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < SETS; i++) arr_mem[i] <= WIDTH'(i + 8);
    end else if (arr_load) begin
      arr_mem[arr_windex] <= arr_datain;
    end
  end

  assign arr_dataout = (arr_load && (arr_windex == arr_rindex)) ? arr_datain
                                                                 : arr_mem[arr_rindex];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic a_r0, input logic a_w0,
                                input logic [S_INDEX-1:0] a_i0, input logic [WIDTH-1:0] a_d0,
                                input logic a_r1, input logic a_w1,
                                input logic [S_INDEX-1:0] a_i1, input logic [WIDTH-1:0] a_d1,
                                input logic a_fl);
    req0 = a_r0; we0 = a_w0; idx0 = a_i0; wdata0 = a_d0;
    req1 = a_r1; we1 = a_w1; idx1 = a_i1; wdata1 = a_d1;
    flush_req = a_fl;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Samples mid-cycle: settles read returns due now, checks grants and the
  // flush pulse, then records what the accepted operations should do.
  task automatic check_output(input string tag, input logic e_rdy0, input logic e_rdy1,
                              input logic e_fd);
    @(negedge clk);
    if (sb0.size() > 0) begin
      check({tag, "/rvalid0"}, 32'(rvalid0), 1);
      check({tag, "/rdata0"}, 32'(rdata0), 32'(sb0.pop_front()));
    end else begin
      check({tag, "/rvalid0"}, 32'(rvalid0), 0);
    end
    if (sb1.size() > 0) begin
      check({tag, "/rvalid1"}, 32'(rvalid1), 1);
      check({tag, "/rdata1"}, 32'(rdata1), 32'(sb1.pop_front()));
    end else begin
      check({tag, "/rvalid1"}, 32'(rvalid1), 0);
    end
    check({tag, "/ready0"}, 32'(ready0), 32'(e_rdy0));
    check({tag, "/ready1"}, 32'(ready1), 32'(e_rdy1));
    check({tag, "/flush_done"}, 32'(flush_done), 32'(e_fd));

    if (e_rdy0 && !we0) sb0.push_back((e_rdy1 && we1 && idx1 == idx0) ? wdata1 : exp_mem[idx0]);
    if (e_rdy1 && !we1) sb1.push_back((e_rdy0 && we0 && idx0 == idx1) ? wdata0 : exp_mem[idx1]);
    if (e_rdy0 && we0) exp_mem[idx0] = wdata0;
    if (e_rdy1 && we1) exp_mem[idx1] = wdata1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    apply_idle();
    for (int i = 0; i < SETS; i++) exp_mem[i] = WIDTH'(i + 8);
    advance();
    preload = 1'b0;

    // Reset held with requests pending: nothing may be accepted.
    apply_stimulus(1'b1, 1'b0, 3'd1, 4'd0, 1'b1, 1'b1, 3'd2, 4'd3, 1'b0);
    check_output("reset", 1'b0, 1'b0, 1'b0);
    check("reset/arr_load", 32'(arr_load), 0);
    check("reset/arr_read", 32'(arr_read), 0);
    check("reset/rdata0", 32'(rdata0), 0);
    check("reset/rdata1", 32'(rdata1), 0);
    advance();
    rst = 1'b0;
    apply_idle();
    check_output("idle", 1'b0, 1'b0, 1'b0);
    advance();

    // Single read of set 5, data returned next cycle.
    apply_stimulus(1'b1, 1'b0, 3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    check_output("rd5", 1'b1, 1'b0, 1'b0);
    check("rd5/arr_read", 32'(arr_read), 1);
    check("rd5/arr_rindex", 32'(arr_rindex), 5);
    advance();
    apply_idle();
    check_output("rd5_ret", 1'b0, 1'b0, 1'b0);
    advance();

    // Write and read of the same set in one cycle: bypassed data returned.
    apply_stimulus(1'b1, 1'b1, 3'd3, 4'd1, 1'b1, 1'b0, 3'd3, 4'd0, 1'b0);
    check_output("wr_rd3", 1'b1, 1'b1, 1'b0);
    check("wr_rd3/arr_load", 32'(arr_load), 1);
    check("wr_rd3/arr_windex", 32'(arr_windex), 3);
    check("wr_rd3/arr_datain", 32'(arr_datain), 1);
    check("wr_rd3/arr_rindex", 32'(arr_rindex), 3);
    advance();
    apply_idle();
    check_output("wr_rd3_ret", 1'b0, 1'b0, 1'b0);
    advance();

    // Competing reads alternate 0,1,0,1 from the reset pointer.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 1'b0, 3'd2, 4'd0, 1'b1, 1'b0, 3'd7, 4'd0, 1'b0);
      check_output("rr_rd", (k % 2) == 0, (k % 2) == 1, 1'b0);
      advance();
    end

    // Competing writes: requester 0 then 1.
    apply_stimulus(1'b1, 1'b1, 3'd1, 4'hA, 1'b1, 1'b1, 3'd4, 4'd5, 1'b0);
    check_output("ww0", 1'b1, 1'b0, 1'b0);
    check("ww0/arr_windex", 32'(arr_windex), 1);
    advance();
    check_output("ww1", 1'b0, 1'b1, 1'b0);
    check("ww1/arr_windex", 32'(arr_windex), 4);
    advance();

    // An uncontested grant must not move the pointer.
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd4, 4'd0, 1'b0);
    check_output("solo1", 1'b0, 1'b1, 1'b0);
    advance();
    apply_stimulus(1'b1, 1'b0, 3'd1, 4'd0, 1'b1, 1'b0, 3'd4, 4'd0, 1'b0);
    check_output("rr_keep", 1'b1, 1'b0, 1'b0);
    advance();
    check_output("rr_flip", 1'b0, 1'b1, 1'b0);
    advance();

    // Read just before a flush; flush beats a same-cycle write; sweep runs.
    apply_stimulus(1'b1, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    check_output("pre_flush_rd", 1'b1, 1'b0, 1'b0);
    advance();
    apply_stimulus(1'b1, 1'b0, 3'd6, 4'd0, 1'b1, 1'b1, 3'd6, 4'd9, 1'b1);
    check_output("flush_start", 1'b0, 1'b0, 1'b0);
    check("flush_start/arr_load", 32'(arr_load), 0);
    check("flush_start/arr_read", 32'(arr_read), 0);
    advance();
    for (int i = 0; i < SETS; i++) exp_mem[i] = '0;
    for (int k = 0; k < SETS; k++) begin
      apply_stimulus(1'b1, 1'b0, 3'd6, 4'd0, 1'b1, 1'b1, 3'd6, 4'd9, k == 3);
      check_output("sweep", 1'b0, 1'b0, 1'b0);
      check("sweep/arr_load", 32'(arr_load), 1);
      check("sweep/arr_windex", 32'(arr_windex), 32'(k));
      check("sweep/arr_datain", 32'(arr_datain), 0);
      advance();
    end
    apply_stimulus(1'b1, 1'b0, 3'd6, 4'd0, 1'b1, 1'b1, 3'd6, 4'd9, 1'b0);
    check_output("flush_done", 1'b1, 1'b1, 1'b1);
    check("flush_done/arr_load", 32'(arr_load), 1);
    check("flush_done/arr_windex", 32'(arr_windex), 6);
    check("flush_done/arr_datain", 32'(arr_datain), 9);
    advance();
    apply_idle();
    check_output("post_flush", 1'b0, 1'b0, 1'b0);
    advance();

    // Sets are cleared, except the write granted after the sweep.
    apply_stimulus(1'b1, 1'b0, 3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    check_output("rd_cleared", 1'b1, 1'b0, 1'b0);
    advance();
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd6, 4'd0, 1'b0);
    check_output("rd_written", 1'b0, 1'b1, 1'b0);
    advance();

    // Leave the pointer at requester 1 so reset has something to restore.
    apply_stimulus(1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0);
    check_output("prio_set", 1'b1, 1'b0, 1'b0);
    advance();

    // Reset during the sweep at set 4: abort, no done pulse, pointer at 0.
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    check_output("flush2", 1'b0, 1'b0, 1'b0);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply_idle();
      check_output("sweep2", 1'b0, 1'b0, 1'b0);
      check("sweep2/arr_windex", 32'(arr_windex), 32'(k));
      advance();
    end
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 3'd2, 4'd0, 1'b1, 1'b0, 3'd7, 4'd0, 1'b0);
    check_output("rst_mid", 1'b0, 1'b0, 1'b0);
    check("rst_mid/arr_load", 32'(arr_load), 0);
    advance();
    rst = 1'b0;
    check_output("after_rst", 1'b1, 1'b0, 1'b0);
    check("after_rst/arr_load", 32'(arr_load), 0);
    advance();
    check_output("after_rst2", 1'b0, 1'b1, 1'b0);
    advance();
    apply_idle();
    check_output("final", 1'b0, 1'b0, 1'b0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/meta_array_ctrl.md
META_ARRAY_CTRL -- requirements
Module: meta_array_ctrl

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, the index width (2**S_INDEX sets).
REQ-002 SHALL have parameter WIDTH, default 1, the entry width.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1, input, 1: requester n has an operation pending.
REQ-006 SHALL have ports we0/we1, input, 1: 1 = write, 0 = read for requester n.
REQ-007 SHALL have ports idx0/idx1, input, S_INDEX: target set for requester n.
REQ-008 SHALL have ports wdata0/wdata1, input, WIDTH: write data for requester n.
REQ-009 SHALL have ports ready0/ready1, output, 1: operation of requester n accepted this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1: read data for requester n valid this cycle.
REQ-011 SHALL have ports rdata0/rdata1, output, WIDTH: registered read data for requester n.
REQ-012 SHALL have port flush_req, input, 1: start an invalidate sweep.
REQ-013 SHALL have port flush_done, output, 1: one-cycle pulse at sweep completion.
REQ-014 SHALL have array-side outputs arr_read (1), arr_load (1), arr_rindex (S_INDEX), arr_windex (S_INDEX), arr_datain (WIDTH), and array-side input arr_dataout (WIDTH). The array reads combinationally and bypasses a same-cycle write to the same index.

Function
REQ-015 SHALL implement the FSM states IDLE and SWEEP. IDLE -> SWEEP on flush_req. SWEEP -> IDLE after the write to the last index.
REQ-016 In IDLE, a requester's operation SHALL be accepted (readyN=1) in the same cycle its reqN is high, subject to the arbitration rules below.
REQ-017 The controller SHALL accept one read and one write from different requesters in the same cycle. Read drives arr_rindex; write drives arr_windex, arr_datain and arr_load.
REQ-018 When both requesters present the same operation type, the requester selected by the round-robin pointer prio SHALL be granted; prio then flips to the other requester.
REQ-019 The prio pointer SHALL change only on a conflicting cycle.
REQ-020 An accepted read SHALL return arr_dataout, registered, with rvalidN=1 on the next cycle. Latency is 1 cycle. rvalidN SHALL be low otherwise.
REQ-021 A read and write to the same index in the same cycle SHALL return the new write data (array bypass).
REQ-022 A requester not granted SHALL hold req, we, idx and wdata stable until readyN=1. The controller SHALL NOT buffer requests.
REQ-023 arr_read SHALL be 1 exactly when a read is accepted. arr_load SHALL be 1 exactly when a write is accepted or in SWEEP.
REQ-024 In SWEEP, a counter SHALL drive arr_windex from 0 to 2**S_INDEX-1, one index per cycle, with arr_datain=0 and arr_load=1.
REQ-025 In SWEEP, ready0 and ready1 SHALL be 0.
REQ-026 flush_done SHALL pulse in the cycle after the last sweep write, coincident with the return to IDLE.
REQ-027 flush_req asserted during SWEEP SHALL be ignored.
REQ-028 If flush_req and reqN are asserted in the same IDLE cycle, the flush SHALL win, with no grant that cycle.
REQ-029 A read accepted in the cycle before entering SWEEP SHALL still deliver its rvalid on the next cycle.
REQ-030 The sweep counter SHALL wrap to 0 on exit from SWEEP.

Reset
REQ-031 On rst the controller SHALL set state=IDLE, prio=0, sweep counter=0, rvalid0/1=0, rdata0/1=0 and flush_done=0.
REQ-032 rst asserted mid-sweep SHALL abort the sweep, return to IDLE and not pulse flush_done.
REQ-033 During rst, all ready, arr_load and arr_read outputs SHALL be 0.

Structure
REQ-034 The state enum (IDLE, SWEEP) SHALL reside in shared package meta_ctrl_pkg.
REQ-035 The two-way round-robin arbiter SHALL be a sub-module rr_arb2 (inputs req[1:0], conflict; outputs gnt[1:0]; internal prio flop).
REQ-036 The controller SHALL instantiate no storage array; it SHALL connect to an external array through the arr_* ports.

Verification
REQ-037 Reset, then req0 read idx=5 -> ready0=1 in cycle 0; rvalid0=1 in cycle 1 with rdata0 equal to the value stored at index 5.
REQ-038 req0 write idx=3 wdata=1 and req1 read idx=3 in the same cycle -> ready0=1, ready1=1; rvalid1=1 next cycle with rdata1=1.
REQ-039 Both requesters read for 4 consecutive cycles from reset -> grant order 0,1,0,1 with prio alternating.
REQ-040 flush_req in IDLE with S_INDEX=3 -> arr_load=1 for 8 cycles with windex 0..7 and datain 0; ready=0 throughout; flush_done pulse in cycle 9; a pending req0 is granted in the same cycle.
REQ-041 rst asserted at sweep index 4 -> state=IDLE next cycle, no flush_done pulse, prio=0.
REQ-042 flush_req together with req1 write -> no arr_load for req1 at that cycle; the write is granted after the sweep.
